// File: rtl/sha256_mc.sv
// Multi-channel SHA-224/256 front-end: NUM_CORES sha256_core engines behind one banked register bus.
// Optional per-channel completed-hash counters are enabled by defining SHA256_MC_STATS_EN.

// state   | meaning
// S_IDLE  | ready for init/next, digest held
// S_ROUND | one compression round per cycle, rnd_q counts down 63..0
// S_FIN   | fold working variables into the chaining value
module sha256_core (
  input  logic         clk_i,
  input  logic         reset_n_i,
  input  logic         init_i,
  input  logic         next_i,
  input  logic         mode_i,
  input  logic [511:0] block_i,
  output logic         ready_o,
  output logic [255:0] digest_o,
  output logic         digest_valid_o
);
  typedef enum logic [1:0] {S_IDLE, S_ROUND, S_FIN} state_t;

  localparam logic [0:63][31:0] K = {
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2};
  localparam logic [7:0][31:0] IV256 = {32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
                                        32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19};
  localparam logic [7:0][31:0] IV224 = {32'hc1059ed8, 32'h367cd507, 32'h3070dd17, 32'hf70e5939,
                                        32'hffc00b31, 32'h68581511, 32'h64f98fa7, 32'hbefa4fa4};

  function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  state_t state_q, state_d;
  logic load, step, fin;
  logic [7:0][31:0]  h_q, v_q;   // index 7 = H0 / a, index 0 = H7 / h
  logic [15:0][31:0] w_q;        // w_q[15] = W[t], w_q[0] = W[t+15]
  logic [5:0]        rnd_q;
  logic              valid_q;
  logic [31:0]       t1, t2, w_new;

  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    step    = 1'b0;
    fin     = 1'b0;
    case (state_q)
      S_IDLE:  if (init_i || next_i) begin load = 1'b1; state_d = S_ROUND; end
      S_ROUND: begin step = 1'b1; if (rnd_q == 6'd0) state_d = S_FIN; end
      S_FIN:   begin fin = 1'b1; state_d = S_IDLE; end
      default: state_d = S_IDLE;
    endcase
  end

  assign t1 = v_q[0] + (rotr(v_q[3], 6) ^ rotr(v_q[3], 11) ^ rotr(v_q[3], 25))
            + ((v_q[3] & v_q[2]) | (~v_q[3] & v_q[1])) + K[~rnd_q] + w_q[15];
  assign t2 = (rotr(v_q[7], 2) ^ rotr(v_q[7], 13) ^ rotr(v_q[7], 22))
            + ((v_q[7] & v_q[6]) ^ (v_q[7] & v_q[5]) ^ (v_q[6] & v_q[5]));
  assign w_new = (rotr(w_q[1], 17) ^ rotr(w_q[1], 19) ^ (w_q[1] >> 10)) + w_q[6]
               + (rotr(w_q[14], 7) ^ rotr(w_q[14], 18) ^ (w_q[14] >> 3)) + w_q[15];

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q <= S_IDLE;
      h_q     <= '0;
      v_q     <= '0;
      w_q     <= '0;
      rnd_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (load) begin
        w_q     <= block_i;
        rnd_q   <= 6'd63;
        valid_q <= 1'b0;
        if (init_i) begin
          h_q <= mode_i ? IV256 : IV224;
          v_q <= mode_i ? IV256 : IV224;
        end else begin
          v_q <= h_q;
        end
      end
      if (step) begin
        v_q   <= {t1 + t2, v_q[7], v_q[6], v_q[5], v_q[4] + t1, v_q[3], v_q[2], v_q[1]};
        w_q   <= {w_q[14:0], w_new};
        rnd_q <= rnd_q - 6'd1;
      end
      if (fin) begin
        for (int i = 0; i < 8; i++) h_q[i] <= h_q[i] + v_q[i];
        valid_q <= 1'b1;
      end
    end
  end

  assign ready_o        = (state_q == S_IDLE);
  assign digest_o       = h_q;
  assign digest_valid_o = valid_q;
endmodule

module sha256_mc #(
  parameter int          NUM_CORES    = 4,
  parameter logic [31:0] CORE_VERSION = 32'h322e3030
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        cs,
  input  logic        we,
  input  logic [11:0] address,
  input  logic [31:0] write_data,
  output logic [31:0] read_data,
  output logic        irq
);
  localparam logic [3:0] GLOBAL_PAGE = 4'hF;

  logic [3:0] page;
  logic [7:0] off;
  logic       wr_glb;
  assign page   = address[11:8];
  assign off    = address[7:0];
  assign wr_glb = cs && we && (page == GLOBAL_PAGE);

  // Block word 0 lives at block_q[c][15] so the packed array is the core's block directly.
  logic [NUM_CORES-1:0][15:0][31:0] block_q;
  logic [NUM_CORES-1:0][7:0][31:0]  digest_q;
  logic [NUM_CORES-1:0][255:0]      core_digest;
  logic [NUM_CORES-1:0] mode_q, init_q, next_q, ready_q, valid_q, rv_q, err_q;
  logic [NUM_CORES-1:0] core_ready, core_valid, done, ch_wr, w1c;
  logic [NUM_CORES-1:0] irq_mask_q, irq_status_q, irq_status_d;
  logic                 irq_q;

  for (genvar g = 0; g < NUM_CORES; g++) begin : g_core
    sha256_core u_core (
      .clk_i          (clk),
      .reset_n_i      (reset_n),
      .init_i         (init_q[g]),
      .next_i         (next_q[g]),
      .mode_i         (mode_q[g]),
      .block_i        (block_q[g]),
      .ready_o        (core_ready[g]),
      .digest_o       (core_digest[g]),
      .digest_valid_o (core_valid[g])
    );
  end

  always_comb begin
    ch_wr = '0;
    for (int c = 0; c < NUM_CORES; c++) ch_wr[c] = cs && we && (page == 4'(c));
  end

  assign done = ready_q & valid_q & ~rv_q;

  // Later assignments to err_q override earlier ones, so a set beats a clear.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      block_q  <= '0;
      digest_q <= '0;
      mode_q   <= '1;
      init_q   <= '0;
      next_q   <= '0;
      ready_q  <= '0;
      valid_q  <= '0;
      rv_q     <= '0;
      err_q    <= '0;
    end else begin
      init_q  <= '0;
      next_q  <= '0;
      ready_q <= core_ready;
      valid_q <= core_valid;
      rv_q    <= ready_q & valid_q;
      for (int c = 0; c < NUM_CORES; c++) begin
        if (core_valid[c]) digest_q[c] <= core_digest[c];
        if (ch_wr[c] && off == 8'h09 && write_data[2]) err_q[c] <= 1'b0;
        if (ch_wr[c] && off == 8'h08) begin
          if ((write_data[0] || write_data[1]) && !ready_q[c]) begin
            err_q[c] <= 1'b1;
          end else begin
            init_q[c] <= write_data[0];
            next_q[c] <= write_data[1];
            mode_q[c] <= write_data[2];
          end
        end
        if (ch_wr[c] && off[7:4] == 4'h1) begin
          if (!ready_q[c]) err_q[c] <= 1'b1;
          else             block_q[c][4'd15 - off[3:0]] <= write_data;
        end
      end
    end
  end

  assign w1c          = (wr_glb && off == 8'h09) ? write_data[NUM_CORES-1:0] : '0;
  assign irq_status_d = done | (irq_status_q & ~w1c);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      irq_mask_q   <= '0;
      irq_status_q <= '0;
      irq_q        <= 1'b0;
    end else begin
      if (wr_glb && off == 8'h08) irq_mask_q <= write_data[NUM_CORES-1:0];
      irq_status_q <= irq_status_d;
      irq_q        <= |(irq_status_d & irq_mask_q);
    end
  end
  assign irq = irq_q;

`ifdef SHA256_MC_STATS_EN
  logic [NUM_CORES-1:0][15:0] cnt_q;
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= '0;
    end else begin
      for (int c = 0; c < NUM_CORES; c++) begin
        if (ch_wr[c] && off == 8'h0C)            cnt_q[c] <= done[c] ? 16'd1 : 16'd0;
        else if (done[c] && cnt_q[c] != 16'hFFFF) cnt_q[c] <= cnt_q[c] + 16'd1;
      end
    end
  end
`endif

  always_comb begin
    read_data = '0;
    if (cs) begin
      if (page == GLOBAL_PAGE) begin
        case (off)
          8'h00:   read_data = 32'h73686132;
          8'h01:   read_data = 32'h2d6d6332;
          8'h02:   read_data = CORE_VERSION;
          8'h03:   read_data = 32'(NUM_CORES);
          8'h08:   read_data = 32'(irq_mask_q);
          8'h09:   read_data = 32'(irq_status_q);
          8'h0A:   read_data = 32'(ready_q);
          8'h0B:   read_data = 32'(valid_q);
          8'h0C:   read_data = 32'(err_q);
          default: read_data = '0;
        endcase
      end else begin
        for (int c = 0; c < NUM_CORES; c++) begin
          if (page == 4'(c)) begin
            case (off)
              8'h08:   read_data = {29'h0, mode_q[c], next_q[c], init_q[c]};
              8'h09:   read_data = {29'h0, err_q[c], valid_q[c], ready_q[c]};
`ifdef SHA256_MC_STATS_EN
              8'h0C:   read_data = {16'h0, cnt_q[c]};
`endif
              default: begin
                if (off[7:4] == 4'h1)          read_data = block_q[c][4'd15 - off[3:0]];
                else if (off[7:3] == 5'b00100) read_data = digest_q[c][3'd7 - off[2:0]];
              end
            endcase
          end
        end
      end
    end
  end
endmodule

// File: tb/tb_sha256_mc.sv
// Directed + randomized bench for sha256_mc; digests are checked against a textbook
// SHA-256 compression model with a full 64-word message schedule.
module tb_sha256_mc;
  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        cs = 1'b0;
  logic        we = 1'b0;
  logic [11:0] address = '0;
  logic [31:0] write_data = '0;
  logic [31:0] read_data;
  logic        irq;
  int n_checks = 0;
  int n_errors = 0;

  sha256_mc dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .cs         (cs),
    .we         (we),
    .address    (address),
    .write_data (write_data),
    .read_data  (read_data),
    .irq        (irq)
  );

  always #5 clk = ~clk;

  localparam logic [31:0] KT [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2};
  localparam logic [255:0] IV256 = {32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
                                    32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19};
  localparam logic [255:0] IV224 = {32'hc1059ed8, 32'h367cd507, 32'h3070dd17, 32'hf70e5939,
                                    32'hffc00b31, 32'h68581511, 32'h64f98fa7, 32'hbefa4fa4};
  localparam logic [255:0] ABC256 = {32'hba7816bf, 32'h8f01cfea, 32'h414140de, 32'h5dae2223,
                                     32'hb00361a3, 32'h96177a9c, 32'hb410ff61, 32'hf20015ad};
  localparam logic [255:0] ABC224 = {32'h23097d22, 32'h3405d822, 32'h8642a477, 32'hbda255b3,
                                     32'h2aadbce4, 32'hbda0b3f7, 32'he36c9da7, 32'h00000000};

  function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [255:0] ref_compress(input logic [255:0] hin, input logic [511:0] blk);
    logic [31:0] w [64];
    logic [31:0] s [8];
    logic [31:0] hh [8];
    logic [31:0] t1, t2;
    logic [255:0] r;
    for (int i = 0; i < 16; i++) w[i] = blk[511 - 32*i -: 32];
    for (int i = 16; i < 64; i++)
      w[i] = (rotr(w[i-2], 17) ^ rotr(w[i-2], 19) ^ (w[i-2] >> 10)) + w[i-7]
           + (rotr(w[i-15], 7) ^ rotr(w[i-15], 18) ^ (w[i-15] >> 3)) + w[i-16];
    for (int i = 0; i < 8; i++) begin
      hh[i] = hin[255 - 32*i -: 32];
      s[i]  = hh[i];
    end
    for (int i = 0; i < 64; i++) begin
      t1 = s[7] + (rotr(s[4], 6) ^ rotr(s[4], 11) ^ rotr(s[4], 25))
         + ((s[4] & s[5]) ^ (~s[4] & s[6])) + KT[i] + w[i];
      t2 = (rotr(s[0], 2) ^ rotr(s[0], 13) ^ rotr(s[0], 22))
         + ((s[0] & s[1]) ^ (s[0] & s[2]) ^ (s[1] & s[2]));
      s[7] = s[6]; s[6] = s[5]; s[5] = s[4]; s[4] = s[3] + t1;
      s[3] = s[2]; s[2] = s[1]; s[1] = s[0]; s[0] = t1 + t2;
    end
    for (int i = 0; i < 8; i++) r[255 - 32*i -: 32] = hh[i] + s[i];
    return r;
  endfunction

  function automatic logic [511:0] rand_blk();
    logic [511:0] b;
    for (int i = 0; i < 16; i++) b[511 - 32*i -: 32] = $urandom();
    return b;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic wr(input logic [3:0] pg, input logic [7:0] of, input logic [31:0] d);
    @(negedge clk);
    cs = 1'b1; we = 1'b1; address = {pg, of}; write_data = d;
    @(negedge clk);
    cs = 1'b0; we = 1'b0;
  endtask

  task automatic rd(input logic [3:0] pg, input logic [7:0] of, output logic [31:0] d);
    @(negedge clk);
    cs = 1'b1; we = 1'b0; address = {pg, of};
    #1 d = read_data;
    cs = 1'b0;
  endtask

  task automatic rd_chk(input logic [3:0] pg, input logic [7:0] of, input logic [31:0] exp, input string tag);
    logic [31:0] d;
    rd(pg, of, d);
    check(tag, d, exp);
  endtask

  task automatic load_block(input logic [3:0] ch, input logic [511:0] b);
    for (int i = 0; i < 16; i++) wr(ch, 8'h10 + 8'(i), b[511 - 32*i -: 32]);
  endtask

  task automatic wait_done(input logic [3:0] ch, input string tag);
    logic [31:0] d;
    bit ok;
    ok = 1'b0;
    repeat (4) @(negedge clk);
    for (int i = 0; i < 400 && !ok; i++) begin
      rd(ch, 8'h09, d);
      if (d[1:0] == 2'b11) ok = 1'b1;
    end
    check($sformatf("%s_done", tag), {31'h0, ok}, 32'h1);
  endtask

  task automatic chk_digest(input logic [3:0] ch, input logic [255:0] exp, input int nw, input string tag);
    for (int i = 0; i < nw; i++)
      rd_chk(ch, 8'h20 + 8'(i), exp[255 - 32*i -: 32], $sformatf("%s_dig%0d", tag, i));
  endtask

  task automatic hash(input logic [3:0] ch, input logic [511:0] b, input logic [31:0] ctrl, input string tag);
    load_block(ch, b);
    wr(ch, 8'h08, ctrl);
    wait_done(ch, tag);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [511:0] abc, rb, rb2;
    logic [255:0] exp;
    logic [3:0]   ch;
    logic         m;
    bit           seen;

    abc = '0;
    abc[511:480] = 32'h61626380;
    abc[31:0]    = 32'h00000018;

    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    repeat (3) @(negedge clk);
    check("irq_rst", {31'h0, irq}, 32'h0);
    rd_chk(4'hF, 8'h00, 32'h73686132, "name0");
    rd_chk(4'hF, 8'h01, 32'h2d6d6332, "name1");
    rd_chk(4'hF, 8'h02, 32'h322e3030, "version");
    rd_chk(4'hF, 8'h03, 32'h00000004, "config");
    rd_chk(4'hF, 8'h08, 32'h0, "mask_rst");
    rd_chk(4'hF, 8'h09, 32'h0, "irqstat_rst");
    rd_chk(4'hF, 8'h0A, 32'h0000000F, "ready_sum_rst");
    rd_chk(4'hF, 8'h0B, 32'h0, "valid_sum_rst");
    rd_chk(4'hF, 8'h0C, 32'h0, "err_sum_rst");
    rd_chk(4'h0, 8'h08, 32'h00000004, "ctrl0_rst");
    rd_chk(4'h0, 8'h09, 32'h00000001, "status0_rst");
    rd_chk(4'h0, 8'h20, 32'h0, "dig0_rst");

    // single SHA-256 "abc" on ch0
    hash(4'h0, abc, 32'h5, "abc0");
    chk_digest(4'h0, ABC256, 8, "abc0");
    rd_chk(4'hF, 8'h09, 32'h1, "irqstat_abc0");
    check("irq_unmasked_abc0", {31'h0, irq}, 32'h0);

    // concurrent ch1 SHA-256 and ch2 SHA-224
    load_block(4'h1, abc);
    load_block(4'h2, abc);
    wr(4'h1, 8'h08, 32'h5);
    wr(4'h2, 8'h08, 32'h1);
    wait_done(4'h1, "abc1");
    wait_done(4'h2, "abc2");
    chk_digest(4'h2, ABC224, 7, "abc224_ch2");
    chk_digest(4'h1, ABC256, 8, "abc256_ch1");
    chk_digest(4'h0, ABC256, 1, "abc256_ch0_kept");
    rd_chk(4'hF, 8'h09, 32'h7, "irqstat_3ch");

    // interrupt masking and W1C
    wr(4'hF, 8'h09, 32'h7);
    rd_chk(4'hF, 8'h09, 32'h0, "irqstat_w1c_all");
    wr(4'hF, 8'h08, 32'h2);
    hash(4'h0, abc, 32'h5, "mask_ch0");
    repeat (3) @(negedge clk);
    check("irq_ch0_masked", {31'h0, irq}, 32'h0);
    rd_chk(4'hF, 8'h09, 32'h1, "irqstat_ch0");
    hash(4'h1, abc, 32'h5, "mask_ch1");
    repeat (2) @(negedge clk);
    check("irq_ch1_unmasked", {31'h0, irq}, 32'h1);
    wr(4'hF, 8'h09, 32'h2);
    @(negedge clk);
    check("irq_after_w1c", {31'h0, irq}, 32'h0);
    rd_chk(4'hF, 8'h09, 32'h1, "irqstat_after_w1c");

    // W1C held on the bus across a new ch1 done event: the set must win
    load_block(4'h1, abc);
    wr(4'h1, 8'h08, 32'h5);
    @(negedge clk);
    cs = 1'b1; we = 1'b1; address = {4'hF, 8'h09}; write_data = 32'h2;
    seen = 1'b0;
    for (int i = 0; i < 400 && !seen; i++) begin
      @(posedge clk);
      #1 if (irq) seen = 1'b1;
    end
    @(negedge clk);
    cs = 1'b0; we = 1'b0;
    check("irq_set_vs_w1c_seen", {31'h0, seen}, 32'h1);
    rd_chk(4'hF, 8'h09, 32'h3, "irqstat_set_wins");
    check("irq_set_wins", {31'h0, irq}, 32'h1);
    wr(4'hF, 8'h09, 32'hF);
    wr(4'hF, 8'h08, 32'h0);

    // busy protection on ch3
    rb = rand_blk();
    load_block(4'h3, rb);
    wr(4'h3, 8'h08, 32'h5);
    repeat (10) @(negedge clk);
    wr(4'h3, 8'h15, 32'hdeadbeef);
    wr(4'h3, 8'h08, 32'h2);
    rd_chk(4'h3, 8'h09, 32'h4, "busy_status");
    rd_chk(4'hF, 8'h0C, 32'h8, "busy_err_sum");
    wait_done(4'h3, "busy");
    rd_chk(4'h3, 8'h15, rb[511 - 32*5 -: 32], "busy_block5_kept");
    chk_digest(4'h3, ref_compress(IV256, rb), 8, "busy");
    rd_chk(4'h3, 8'h09, 32'h7, "busy_status_done");
    wr(4'h3, 8'h09, 32'h4);
    rd_chk(4'h3, 8'h09, 32'h3, "err_cleared");
    repeat (100) @(negedge clk);
    chk_digest(4'h3, ref_compress(IV256, rb), 8, "busy_no_extra");

    // randomized init + next chains on random channels and modes
    for (int k = 0; k < 4; k++) begin
      ch  = 4'($urandom_range(0, 3));
      m   = 1'($urandom_range(0, 1));
      rb  = rand_blk();
      rb2 = rand_blk();
      exp = ref_compress(m ? IV256 : IV224, rb);
      hash(ch, rb, {29'h0, m, 2'b01}, $sformatf("rnd%0d_init", k));
      chk_digest(ch, exp, m ? 8 : 7, $sformatf("rnd%0d_init", k));
      exp = ref_compress(exp, rb2);
      hash(ch, rb2, {29'h0, m, 2'b10}, $sformatf("rnd%0d_next", k));
      chk_digest(ch, exp, m ? 8 : 7, $sformatf("rnd%0d_next", k));
    end
    wr(4'hF, 8'h09, 32'hF);

    // reset asserted in the middle of a ch0 hash
    wr(4'hF, 8'h08, 32'h1);
    load_block(4'h0, abc);
    wr(4'h0, 8'h08, 32'h5);
    repeat (20) @(negedge clk);
    #2 reset_n = 1'b0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    repeat (3) @(negedge clk);
    rd_chk(4'hF, 8'h0A, 32'h0000000F, "ready_after_rst");
    rd_chk(4'h0, 8'h20, 32'h0, "dig0_after_rst");
    rd_chk(4'h0, 8'h09, 32'h1, "status0_after_rst");
    repeat (150) @(negedge clk);
    check("irq_after_rst", {31'h0, irq}, 32'h0);
    rd_chk(4'hF, 8'h09, 32'h0, "irqstat_after_rst");
    rd_chk(4'h0, 8'h09, 32'h1, "status0_late_after_rst");

    // decode boundaries
    wr(4'h5, 8'h10, 32'h12345678);
    wr(4'h5, 8'h08, 32'h1);
    wr(4'h4, 8'h10, 32'hcafef00d);
    rd_chk(4'h5, 8'h10, 32'h0, "page5_read");
    rd_chk(4'h4, 8'h10, 32'h0, "page4_read");
    rd_chk(4'h1, 8'h10, 32'h0, "page5_no_alias_ch1");
    rd_chk(4'h0, 8'h10, 32'h0, "page4_no_alias_ch0");
    rd_chk(4'hF, 8'h0C, 32'h0, "bad_page_no_err");
    rd_chk(4'h0, 8'h30, 32'h0, "unmapped_offset");
    rd_chk(4'hF, 8'h04, 32'h0, "unmapped_global");

`ifdef SHA256_MC_STATS_EN
    wr(4'h0, 8'h0C, 32'h0);
    for (int k = 0; k < 3; k++) hash(4'h0, abc, 32'h5, $sformatf("stats%0d", k));
    rd_chk(4'h0, 8'h0C, 32'h3, "stats_count");
    rd_chk(4'h1, 8'h0C, 32'h0, "stats_ch1_idle");
    wr(4'h0, 8'h0C, 32'h0);
    rd_chk(4'h0, 8'h0C, 32'h0, "stats_cleared");
`else
    wr(4'h0, 8'h0C, 32'hFFFF);
    hash(4'h0, abc, 32'h5, "nostats");
    rd_chk(4'h0, 8'h0C, 32'h0, "stats_absent");
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/sha256_mc.md
Name: sha256_mc

Overview:
Multi-channel SHA-224/256 register front-end. It instantiates NUM_CORES independent sha256_core engines behind one banked 32-bit cs/we/address bus. Each channel has its own block, control, status and digest registers. A global page adds a per-channel interrupt mask, sticky W1C done status, busy-write error flags and ready/valid summaries. Used as the SoC-facing hashing peripheral wherever more than one hash stream runs concurrently.

Parameters:
NUM_CORES, 4, number of channels/cores; legal range 1..15.
CORE_VERSION, 32'h322e3030, value returned at global VERSION ("2.00").

Ports:
clk  input  1  clock
reset_n  input  1  asynchronous active-low reset
cs  input  1  bus select
we  input  1  write strobe (valid with cs)
address  input  12  [11:8] page (0..NUM_CORES-1 = channel, 0xF = global), [7:0] offset
write_data  input  32  write data
read_data  output  32  read data, combinational from address in the same cycle
irq  output  1  level interrupt: OR over channels of (irq_status & irq_mask)

Behaviour:
- Reset and clock: reset reset_n, asynchronous, active-low; clock clk.
- Reset values:
  - read_data is driven 0 whenever cs is low.
  - irq = 0; all block/digest registers 0; init/next pulses 0.
  - mode = 1 (SHA-256) on every channel.
  - irq_mask = 0, irq_status = 0, err = 0.
- Channel page offsets:
  - 0x08 CTRL, write:
    - bit0 init, bit1 next: single-cycle pulses to the core, asserted the cycle after the write.
    - bit2 mode: latched on every CTRL write.
    - Read returns {29'h0, mode, next_pulse, init_pulse}.
  - 0x09 STATUS, read: {29'h0, err, valid_reg, ready_reg}.
    - ready_reg and valid_reg are the core's ready and digest_valid, each registered one cycle.
    - Writing bit2 = 1 clears err.
  - 0x10..0x1F BLOCK0..15, R/W. Word 0 maps to block[511:480].
  - 0x20..0x27 DIGEST0..7, read-only. Holds the last valid digest; DIGEST0 = digest[255:224]. Updated whenever core digest_valid is high.
  - Other offsets read 0; writes to them are ignored.
- Busy protection, per channel:
  - A CTRL write with init|next = 1 while ready_reg = 0 produces no pulse and sets err. The mode bit is still ignored in that case.
  - A BLOCK write while ready_reg = 0 is dropped and sets err.
  - If an err set and an err clear happen in the same cycle, set wins.
- Global page (0xF) offsets:
  - 0x00 NAME0 = 32'h73686132
  - 0x01 NAME1 = 32'h2d6d6332 ("-mc2")
  - 0x02 VERSION = CORE_VERSION
  - 0x03 CONFIG = NUM_CORES (zero-extended)
  - 0x08 IRQ_MASK, R/W, bits [NUM_CORES-1:0]
  - 0x09 IRQ_STATUS, R/W1C
  - 0x0A READY summary (read-only)
  - 0x0B VALID summary (read-only)
  - 0x0C ERR summary (read-only)
  - Bits at or above NUM_CORES read 0.
- Done event, per channel: rising edge of (ready_reg & valid_reg), detected with a one-cycle-delayed copy.
  - Sets irq_status[ch] unconditionally; the mask gates only the irq output.
  - If a set and a W1C clear of the same bit land in the same cycle, set wins.
  - irq is a registered output; it rises two cycles after the core's ready/digest_valid go high.
- Page decoding: a page >= NUM_CORES other than 0xF reads 0; writes to it are ignored and set no flags.
- Reset asserted mid-hash: all channel and core state is cleared asynchronously; no done event follows deassertion.
- Channels are fully independent. Simultaneous done events on several channels each set their own bit in the same cycle.

Optional Feature:
- Macro: SHA256_MC_STATS_EN.
- When defined:
  - Each channel gets a 16-bit completed-hash counter at channel offset 0x0C, bits [15:0].
  - The counter increments on every done event and saturates at 16'hFFFF.
  - Writing any value to 0x0C clears it; if a clear and an increment land in the same cycle, the result is 1.
- When not defined: offset 0x0C reads 0, writes to it are ignored, and no counter flops exist.

Test Plan:
- Reset, then read the global page: NAME0 = 73686132, CONFIG = 00000004, IRQ_STATUS = 0, READY summary = 0000000F once the cores are idle. Read CTRL on ch0: 00000004 (mode = 1).
- ch0 SHA-256 "abc":
  - Stimulus: BLOCK0 = 61626380, BLOCK15 = 00000018, all other words 0; then CTRL = 00000005.
  - Required: DIGEST0..7 = ba7816bf 8f01cfea 414140de 5dae2223 b00361a3 96177a9c b410ff61 f20015ad, and IRQ_STATUS bit0 = 1.
- ch2 SHA-224 "abc" (CTRL = 00000001) runs concurrently with ch1 SHA-256 "abc".
  - Required: ch2 DIGEST0..6 = 23097d22 3405d822 8642a477 bda255b3 2aadbce4 bda0b3f7 e36c9da7.
  - Required: ch1 DIGEST matches the scenario-2 values, and no cross-channel corruption occurs.
- Interrupt masking and clearing:
  - IRQ_MASK = 00000002 and ch1 completes -> irq = 1, while ch0 completion alone leaves irq = 0.
  - W1C 00000002 -> irq = 0.
  - W1C issued in the same cycle as a new ch1 done event -> the bit stays 1.
- Busy protection: during an active ch3 hash, write BLOCK5 = deadbeef and CTRL = 00000002.
  - Required: BLOCK5 is unchanged, no extra hash runs, and STATUS = 00000004 (err set).
  - Writing STATUS = 00000004 then returns err = 0.
- Reset and decode boundaries:
  - Assert reset_n low mid-hash on ch0 -> ready summary returns and DIGEST = 0 with no irq.
  - Write to page 5 with NUM_CORES = 4 -> ignored, reads 0.
  - With SHA256_MC_STATS_EN defined, three hashes on ch0 -> offset 0x0C reads 00000003.
